sensor_ni: RTL and testbench
============================

# sensor_ni

Network interface between a sensor node and its local router port. On the transmit side it packs sensor samples into head/body/tail flit packets and injects them into the router input port over a valid/ready flit link. On the receive side it accepts flits ejected by the router output port, checks packet framing and destination, and delivers payload words to the node with start/end-of-packet marks. It is the endpoint counterpart of the router port: its flit output drives the router's flit input and vice versa.

## Interface
- FLIT_W, 32, flit width; data width DATA_W = FLIT_W-2
- ADDR_W, 4, node address width
- NODE_ID, 0, this node's address (ADDR_W bits)
- PKT_LEN, 4, payload (body+tail) flits per transmitted packet, >=1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_dest_i  in  ADDR_W  destination for transmitted packets, sampled at head build
- smp_data_i  in  DATA_W  sensor sample
- smp_vld_i  in  1  sample valid
- smp_rdy_o  out  1  sample accepted when smp_vld_i & smp_rdy_o
- out_flit_o  out  FLIT_W  flit to router input
- out_vld_o  out  1  flit valid
- out_rdy_i  in  1  router accepts flit
- in_flit_i  in  FLIT_W  flit from router output
- in_vld_i  in  1  flit valid
- in_rdy_o  out  1  NI accepts flit
- rx_data_o  out  DATA_W  received payload word
- rx_src_o  out  ADDR_W  source of current packet
- rx_sop_o / rx_eop_o  out  1  first / last word of packet
- rx_vld_o  out  1  word valid
- rx_rdy_i  in  1  consumer accepts word
- err_cnt_o  out  8  saturating framing-error count

## Operation
- Flit type [FLIT_W-1:FLIT_W-2]: 01 head, 00 body, 10 tail, 11 reserved. Head: [FLIT_W-3 -: ADDR_W] dest, next ADDR_W bits src (=NODE_ID), next 8 bits seq, rest 0. Body/tail: [DATA_W-1:0] data.
- TX FSM: IDLE -> HEAD -> BODY -> IDLE. IDLE: smp_rdy_o=0; on smp_vld_i load head flit (dest=cfg_dest_i, seq) into output register, go HEAD. HEAD: hold until out_rdy_i, go BODY. BODY: smp_rdy_o = ~out_vld_o | out_rdy_i; each accepted sample loads a body flit, the PKT_LEN-th a tail flit; after tail loaded go IDLE (tail may still be pending in output register; IDLE does not load a new head until it is accepted).
- seq starts 0, increments on each head acceptance, wraps 255->0. Packets are never interleaved. If PKT_LEN=1 the single payload flit is a tail.
- RX: one-entry output register; in_rdy_o = ~rx_vld_o | rx_rdy_i in every state. RX FSM: WAIT_HEAD, PAYLOAD, DROP.
  - WAIT_HEAD: head with dest==NODE_ID -> capture src, go PAYLOAD, nothing output. Head with other dest -> err+1, go DROP. Body/tail/reserved -> discard, err+1.
  - PAYLOAD: body -> output word, rx_sop_o=1 on first word of packet. Tail -> output with rx_eop_o=1, go WAIT_HEAD. Head -> err+1, treated as a fresh head (prior packet ends without eop). Reserved -> discard, err+1, go DROP.
  - DROP: discard all until tail (-> WAIT_HEAD) or head (evaluate as in WAIT_HEAD).
- err_cnt_o saturates at 255.

## Timing
- Reset (rst low, async): out_vld_o=0, out_flit_o=0, smp_rdy_o=0, in_rdy_o=1 after release, rx_vld_o=0, rx_data_o=0, rx_src_o=0, rx_sop_o=0, rx_eop_o=0, err_cnt_o=0, seq=0, FSMs IDLE/WAIT_HEAD. Reset mid-packet discards the partial packet on both sides.
- out_flit_o/out_vld_o and rx_* are registered; all hold stable while valid & ~ready.
- TX latency: smp_vld_i at edge N in IDLE -> head valid after edge N; with out_rdy_i held 1, one flit per cycle, packet of PKT_LEN+1 flits in PKT_LEN+1 consecutive cycles.
- RX latency: flit accepted at edge N -> word valid after edge N; full throughput with rx_rdy_i=1.
- Simultaneous accept and reload of an output register in the same cycle is required (no bubble).

## Test plan
- PKT_LEN=4, cfg_dest=3, samples 1..4, out_rdy_i=1 -> flits head(dest 3, src 0, seq 0), body 1, body 2, body 3, tail 4 in 5 cycles; next packet seq=1.
- out_rdy_i toggling 1/0 each cycle -> same flit sequence, no loss/duplication, flits stable while stalled; 256 packets -> seq wraps to 0.
- RX: head(dest NODE_ID, src 5), body A, body B, tail C -> words A(sop), B, C(eop), rx_src_o=5, err_cnt_o=0.
- RX: head with dest!=NODE_ID followed by 3 bodies and tail -> nothing output, err_cnt_o=1; following valid packet delivered intact.
- RX: body without head, then head mid-packet -> err_cnt_o increments each time; 300 bad flits -> err_cnt_o=255.
- Assert rst mid-packet on both sides -> all outputs reset immediately; next packet framed correctly from seq 0.

Source files
------------

// File: rtl/sensor_ni.sv
// sensor_ni: network interface between a sensor node and its router port.
//
// TX path packs sensor samples into head/body/tail flit packets and drives
// them into the router input over a valid/ready flit link. RX path accepts
// flits ejected by the router, checks framing and destination, and hands
// payload words to the node with start/end-of-packet marks.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   cfg_dest_i   destination for transmitted packets (sampled at head build)
//   smp_data_i   sensor sample;            smp_vld_i / smp_rdy_o handshake
//   out_flit_o   flit to router input;     out_vld_o / out_rdy_i handshake
//   in_flit_i    flit from router output;  in_vld_i  / in_rdy_o  handshake
//   rx_data_o    received payload word;    rx_vld_o  / rx_rdy_i  handshake
//   rx_src_o     source address of the packet currently being delivered
//   rx_sop_o     first word of packet
//   rx_eop_o     last word of packet
//   err_cnt_o    saturating framing-error count
//
// Flit format: [FLIT_W-1:FLIT_W-2] type (01 head, 00 body, 10 tail, 11 rsvd)
//   head: dest | src | seq[7:0] | zero pad
//   body/tail: payload in [DATA_W-1:0]
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | no packet open; builds a head once the previous tail is gone
//   TX_HEAD  | head waiting in the output register
//   TX_BODY  | accepting samples as body flits, last one as tail
//
// RX FSM
//   state        | meaning
//   RX_WAIT_HEAD | expecting a head flit
//   RX_PAYLOAD   | inside a packet addressed to this node
//   RX_DROP      | discarding flits until a tail or a new head

module sensor_ni #(
  parameter int                FLIT_W  = 32,
  parameter int                ADDR_W  = 4,
  parameter logic [ADDR_W-1:0] NODE_ID = '0,
  parameter int                PKT_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   cfg_dest_i,
  input  logic [FLIT_W-3:0]   smp_data_i,
  input  logic                smp_vld_i,
  output logic                smp_rdy_o,
  output logic [FLIT_W-1:0]   out_flit_o,
  output logic                out_vld_o,
  input  logic                out_rdy_i,
  input  logic [FLIT_W-1:0]   in_flit_i,
  input  logic                in_vld_i,
  output logic                in_rdy_o,
  output logic [FLIT_W-3:0]   rx_data_o,
  output logic [ADDR_W-1:0]   rx_src_o,
  output logic                rx_sop_o,
  output logic                rx_eop_o,
  output logic                rx_vld_o,
  input  logic                rx_rdy_i,
  output logic [7:0]          err_cnt_o
);

  localparam int DATA_W = FLIT_W - 2;
  localparam int CNT_W  = $clog2(PKT_LEN + 1);
  localparam int PAD_W  = FLIT_W - 2 - 2*ADDR_W - 8;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  // ---------------------------------------------------------------- TX ----
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HEAD = 2'd1,
    TX_BODY = 2'd2
  } tx_state_t;

  tx_state_t           r_tx_state;
  logic [FLIT_W-1:0]   r_out_flit;
  logic                r_out_vld;
  logic [7:0]          r_seq;
  logic [CNT_W-1:0]    r_tx_cnt;   // payload flits still to load

  logic                w_out_acc;
  logic                w_out_free;
  logic                w_smp_acc;
  logic                w_last;
  logic [FLIT_W-1:0]   w_head_flit;

  assign w_out_acc   = r_out_vld & out_rdy_i;
  // output register can take a new flit this edge (empty or being drained)
  assign w_out_free  = ~r_out_vld | out_rdy_i;
  assign smp_rdy_o   = (r_tx_state != TX_IDLE) & w_out_free;
  assign w_smp_acc   = smp_vld_i & smp_rdy_o;
  assign w_last      = (r_tx_cnt == CNT_W'(1));
  assign w_head_flit = {T_HEAD, cfg_dest_i, NODE_ID, r_seq, {PAD_W{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_out_flit <= '0;
      r_out_vld  <= 1'b0;
      r_seq      <= '0;
      r_tx_cnt   <= '0;
    end else begin
      if (w_out_acc) begin
        r_out_vld <= 1'b0;
      end

      case (r_tx_state)
        TX_IDLE: begin
          // a pending tail must leave (or leave this edge) before the head
          if (smp_vld_i && w_out_free) begin
            r_out_flit <= w_head_flit;
            r_out_vld  <= 1'b1;
            r_tx_cnt   <= CNT_W'(PKT_LEN);
            r_tx_state <= TX_HEAD;
          end
        end
        TX_HEAD: begin
          if (out_rdy_i) begin
            r_seq      <= r_seq + 8'd1;
            r_tx_state <= TX_BODY;
          end
        end
        TX_BODY: begin
        end
        default: r_tx_state <= TX_IDLE;
      endcase

      // Samples are accepted in HEAD too, in the cycle the head leaves, so
      // the packet streams without a bubble after the head.
      if (w_smp_acc) begin
        r_out_flit <= {(w_last ? T_TAIL : T_BODY), smp_data_i};
        r_out_vld  <= 1'b1;
        r_tx_cnt   <= r_tx_cnt - CNT_W'(1);
        if (w_last) begin
          r_tx_state <= TX_IDLE;
        end
      end
    end
  end

  assign out_flit_o = r_out_flit;
  assign out_vld_o  = r_out_vld;

  // ---------------------------------------------------------------- RX ----
  typedef enum logic [1:0] {
    RX_WAIT_HEAD = 2'd0,
    RX_PAYLOAD   = 2'd1,
    RX_DROP      = 2'd2
  } rx_state_t;

  rx_state_t           r_rx_state;
  logic [DATA_W-1:0]   r_rx_data;
  logic [ADDR_W-1:0]   r_rx_src;
  logic                r_rx_sop;
  logic                r_rx_eop;
  logic                r_rx_vld;
  logic                r_first;    // next delivered word opens the packet
  logic [7:0]          r_err;

  logic                w_in_rdy;
  logic                w_in_acc;
  logic [1:0]          w_in_type;
  logic [ADDR_W-1:0]   w_in_dest;
  logic [ADDR_W-1:0]   w_in_src;
  logic                w_dest_ok;
  rx_state_t           w_rx_next;
  logic                w_load;
  logic                w_eop;
  logic                w_cap;
  logic [1:0]          w_err_inc;
  logic [8:0]          w_err_sum;

  assign w_in_rdy  = ~r_rx_vld | rx_rdy_i;
  assign w_in_acc  = in_vld_i & w_in_rdy;
  assign w_in_type = in_flit_i[FLIT_W-1 -: 2];
  assign w_in_dest = in_flit_i[FLIT_W-3 -: ADDR_W];
  assign w_in_src  = in_flit_i[FLIT_W-3-ADDR_W -: ADDR_W];
  assign w_dest_ok = (w_in_dest == NODE_ID);
  assign w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};

  always_comb begin
    w_rx_next = r_rx_state;
    w_load    = 1'b0;
    w_eop     = 1'b0;
    w_cap     = 1'b0;
    w_err_inc = 2'd0;
    if (w_in_acc) begin
      case (r_rx_state)
        RX_PAYLOAD: begin
          case (w_in_type)
            T_BODY: w_load = 1'b1;
            T_TAIL: begin
              w_load    = 1'b1;
              w_eop     = 1'b1;
              w_rx_next = RX_WAIT_HEAD;
            end
            T_HEAD: begin
              // open packet is abandoned (one error); the head is then
              // judged on its own, adding a second error if misaddressed
              w_err_inc = w_dest_ok ? 2'd1 : 2'd2;
              w_cap     = w_dest_ok;
              w_rx_next = w_dest_ok ? RX_PAYLOAD : RX_DROP;
            end
            default: begin
              w_err_inc = 2'd1;
              w_rx_next = RX_DROP;
            end
          endcase
        end
        default: begin
          if (w_in_type == T_HEAD) begin
            w_err_inc = w_dest_ok ? 2'd0 : 2'd1;
            w_cap     = w_dest_ok;
            w_rx_next = w_dest_ok ? RX_PAYLOAD : RX_DROP;
          end else if (r_rx_state == RX_WAIT_HEAD) begin
            w_err_inc = 2'd1;
          end else if (w_in_type == T_TAIL) begin
            w_rx_next = RX_WAIT_HEAD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RX_WAIT_HEAD;
      r_rx_data  <= '0;
      r_rx_src   <= '0;
      r_rx_sop   <= 1'b0;
      r_rx_eop   <= 1'b0;
      r_rx_vld   <= 1'b0;
      r_first    <= 1'b0;
      r_err      <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      if (r_rx_vld && rx_rdy_i) begin
        r_rx_vld <= 1'b0;
      end
      if (w_load) begin
        r_rx_vld  <= 1'b1;
        r_rx_data <= in_flit_i[DATA_W-1:0];
        r_rx_sop  <= r_first;
        r_rx_eop  <= w_eop;
        r_first   <= 1'b0;
      end
      if (w_cap) begin
        r_rx_src <= w_in_src;
        r_first  <= 1'b1;
      end
      if (w_err_inc != 2'd0) begin
        r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      end
    end
  end

  assign in_rdy_o  = w_in_rdy;
  assign rx_data_o = r_rx_data;
  assign rx_src_o  = r_rx_src;
  assign rx_sop_o  = r_rx_sop;
  assign rx_eop_o  = r_rx_eop;
  assign rx_vld_o  = r_rx_vld;
  assign err_cnt_o = r_err;

endmodule

// File: tb/tb_sensor_ni.sv
// Self-checking bench for sensor_ni: TX and RX scoreboards fed by the
// stimulus tasks and drained by negedge monitors.
module tb_sensor_ni;

  localparam int          FLIT_W  = 32;
  localparam int          ADDR_W  = 4;
  localparam int          DATA_W  = FLIT_W - 2;
  localparam int          PKT_LEN = 4;
  localparam logic [3:0]  NODE_ID = 4'd0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        cfg_dest_i = '0;
  logic [DATA_W-1:0] smp_data_i = '0;
  logic              smp_vld_i = 1'b0;
  logic              smp_rdy_o;
  logic [FLIT_W-1:0] out_flit_o;
  logic              out_vld_o;
  logic              out_rdy_i = 1'b1;
  logic [FLIT_W-1:0] in_flit_i = '0;
  logic              in_vld_i = 1'b0;
  logic              in_rdy_o;
  logic [DATA_W-1:0] rx_data_o;
  logic [3:0]        rx_src_o;
  logic              rx_sop_o;
  logic              rx_eop_o;
  logic              rx_vld_o;
  logic              rx_rdy_i = 1'b1;
  logic [7:0]        err_cnt_o;

  sensor_ni #(
    .FLIT_W (FLIT_W),
    .ADDR_W (ADDR_W),
    .NODE_ID(NODE_ID),
    .PKT_LEN(PKT_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_dest_i(cfg_dest_i),
    .smp_data_i(smp_data_i),
    .smp_vld_i (smp_vld_i),
    .smp_rdy_o (smp_rdy_o),
    .out_flit_o(out_flit_o),
    .out_vld_o (out_vld_o),
    .out_rdy_i (out_rdy_i),
    .in_flit_i (in_flit_i),
    .in_vld_i  (in_vld_i),
    .in_rdy_o  (in_rdy_o),
    .rx_data_o (rx_data_o),
    .rx_src_o  (rx_src_o),
    .rx_sop_o  (rx_sop_o),
    .rx_eop_o  (rx_eop_o),
    .rx_vld_o  (rx_vld_o),
    .rx_rdy_i  (rx_rdy_i),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FLIT_W-1:0] f_head(input logic [3:0] d, input logic [3:0] s, input logic [7:0] q);
    return {2'b01, d, s, q, 14'd0};
  endfunction
  function automatic logic [FLIT_W-1:0] f_body(input logic [DATA_W-1:0] d);
    return {2'b00, d};
  endfunction
  function automatic logic [FLIT_W-1:0] f_tail(input logic [DATA_W-1:0] d);
    return {2'b10, d};
  endfunction
  function automatic logic [FLIT_W-1:0] f_rsvd(input logic [DATA_W-1:0] d);
    return {2'b11, d};
  endfunction

  // scoreboards: TX holds flits, RX holds {src, sop, eop, data}
  logic [FLIT_W-1:0] tx_q[$];
  logic [35:0]       rx_q[$];
  logic [7:0]        tb_seq = '0;

  int   cyc = 0;
  always @(posedge clk) cyc++;

  // background ready drivers
  logic tx_tog  = 1'b0;
  logic rx_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    if (tx_tog)  out_rdy_i = ~out_rdy_i;
    if (rx_rand) rx_rdy_i  = 1'($urandom_range(0, 1));
  end

  // monitors
  logic              mon_en  = 1'b1;
  logic              tput_en = 1'b0;
  logic              tx_hold_v = 1'b0;
  logic [FLIT_W-1:0] tx_hold_f = '0;
  logic              rx_hold_v = 1'b0;
  logic [35:0]       rx_hold_w = '0;
  logic [FLIT_W-1:0] tx_exp;
  logic [35:0]       rx_exp;
  logic [35:0]       rx_obs;
  int                cyc_head = 0;

  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      tx_hold_v = 1'b0;
      rx_hold_v = 1'b0;
    end else begin
      if (out_vld_o) begin
        if (tx_hold_v) check_val("tx_stable", 64'(out_flit_o), 64'(tx_hold_f));
        if (out_rdy_i) begin
          if (tx_q.size() == 0) begin
            check_val("tx_unexpected", 64'(tx_q.size()), 64'd1);
          end else begin
            tx_exp = tx_q.pop_front();
            check_val("tx_flit", 64'(out_flit_o), 64'(tx_exp));
          end
          if (out_flit_o[FLIT_W-1 -: 2] == 2'b01) cyc_head = cyc;
          else if (out_flit_o[FLIT_W-1 -: 2] == 2'b10 && tput_en)
            check_val("tx_tput", 64'(cyc - cyc_head), 64'(PKT_LEN));
          tx_hold_v = 1'b0;
        end else begin
          tx_hold_v = 1'b1;
          tx_hold_f = out_flit_o;
        end
      end else begin
        tx_hold_v = 1'b0;
      end

      rx_obs = {rx_src_o, rx_sop_o, rx_eop_o, rx_data_o};
      if (rx_vld_o) begin
        if (rx_hold_v) check_val("rx_stable", 64'(rx_obs), 64'(rx_hold_w));
        if (rx_rdy_i) begin
          if (rx_q.size() == 0) begin
            check_val("rx_unexpected", 64'(rx_q.size()), 64'd1);
          end else begin
            rx_exp = rx_q.pop_front();
            check_val("rx_word", 64'(rx_obs), 64'(rx_exp));
          end
          rx_hold_v = 1'b0;
        end else begin
          rx_hold_v = 1'b1;
          rx_hold_w = rx_obs;
        end
      end else begin
        rx_hold_v = 1'b0;
      end
    end
  end

  task automatic tx_sample(input logic [DATA_W-1:0] d);
    logic ok;
    ok = 1'b0;
    smp_data_i = d;
    smp_vld_i  = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      ok = smp_rdy_o;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check_val("smp_timeout", 64'(smp_rdy_o), 64'd1);
    smp_vld_i = 1'b0;
  endtask

  task automatic tx_packet(input logic [3:0] dest, input bit count_data);
    logic [DATA_W-1:0] d;
    cfg_dest_i = dest;
    tx_q.push_back(f_head(dest, NODE_ID, tb_seq));
    tb_seq = tb_seq + 8'd1;
    for (int i = 0; i < PKT_LEN; i++) begin
      d = count_data ? DATA_W'(i + 1) : DATA_W'($urandom);
      tx_q.push_back((i == PKT_LEN - 1) ? f_tail(d) : f_body(d));
      tx_sample(d);
    end
  endtask

  task automatic rx_flit(input logic [FLIT_W-1:0] f);
    logic ok;
    ok = 1'b0;
    in_flit_i = f;
    in_vld_i  = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      ok = in_rdy_o;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check_val("in_timeout", 64'(in_rdy_o), 64'd1);
    in_vld_i = 1'b0;
  endtask

  task automatic rx_expect(input logic [3:0] s, input logic sop, input logic eop, input logic [DATA_W-1:0] d);
    rx_q.push_back({s, sop, eop, d});
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      if (tx_q.size() == 0 && rx_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("tx_drain", 64'(tx_q.size()), 64'd0);
    check_val("rx_drain", 64'(rx_q.size()), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  localparam logic [DATA_W-1:0] WA = 30'h0AAAAAAA;
  localparam logic [DATA_W-1:0] WB = 30'h15555555;
  localparam logic [DATA_W-1:0] WC = 30'h3C3C3C3C;

  initial begin
    // reset state
    #12;
    check_val("rst_out_vld", 64'(out_vld_o), 64'd0);
    check_val("rst_out_flit", 64'(out_flit_o), 64'd0);
    check_val("rst_smp_rdy", 64'(smp_rdy_o), 64'd0);
    check_val("rst_rx_vld", 64'(rx_vld_o), 64'd0);
    check_val("rst_rx_data", 64'(rx_data_o), 64'd0);
    check_val("rst_rx_src", 64'(rx_src_o), 64'd0);
    check_val("rst_err", 64'(err_cnt_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_in_rdy", 64'(in_rdy_o), 64'd1);
    @(posedge clk); #1;

    // TX back-to-back with samples 1..4, two packets
    tput_en = 1'b1;
    tx_packet(4'd3, 1'b1);
    tx_packet(4'd3, 1'b1);
    drain();
    tput_en = 1'b0;

    // TX with toggling ready; 256 packets wrap the sequence number
    tx_tog = 1'b1;
    for (int p = 0; p < 256; p++) tx_packet(4'($urandom_range(0, 15)), 1'b0);
    drain();
    tx_tog = 1'b0;
    @(negedge clk);
    out_rdy_i = 1'b1;
    @(posedge clk); #1;

    // RX: well-formed packet from node 5
    rx_expect(4'd5, 1'b1, 1'b0, WA);
    rx_expect(4'd5, 1'b0, 1'b0, WB);
    rx_expect(4'd5, 1'b0, 1'b1, WC);
    rx_flit(f_head(NODE_ID, 4'd5, 8'd0));
    rx_flit(f_body(WA));
    rx_flit(f_body(WB));
    rx_flit(f_tail(WC));
    drain();
    check_val("err_after_good", 64'(err_cnt_o), 64'd0);

    // RX: misaddressed packet dropped, then a good one
    rx_flit(f_head(4'd3, 4'd2, 8'd7));
    for (int i = 0; i < 3; i++) rx_flit(f_body(DATA_W'(i)));
    rx_flit(f_tail(WC));
    rx_expect(4'd7, 1'b1, 1'b0, WB);
    rx_expect(4'd7, 1'b0, 1'b1, WA);
    rx_flit(f_head(NODE_ID, 4'd7, 8'd1));
    rx_flit(f_body(WB));
    rx_flit(f_tail(WA));
    drain();
    check_val("err_misaddr", 64'(err_cnt_o), 64'd1);

    // RX: orphan body, then a head arriving mid-packet
    rx_flit(f_body(WA));
    rx_expect(4'd1, 1'b1, 1'b0, WA);
    rx_expect(4'd9, 1'b1, 1'b0, WB);
    rx_expect(4'd9, 1'b0, 1'b1, WC);
    rx_flit(f_head(NODE_ID, 4'd1, 8'd2));
    rx_flit(f_body(WA));
    rx_flit(f_head(NODE_ID, 4'd9, 8'd3));
    rx_flit(f_body(WB));
    rx_flit(f_tail(WC));
    drain();
    check_val("err_orphan_midhead", 64'(err_cnt_o), 64'd3);

    // RX: reserved flit mid-packet drops the rest of it
    rx_expect(4'd2, 1'b1, 1'b0, WC);
    rx_flit(f_head(NODE_ID, 4'd2, 8'd4));
    rx_flit(f_body(WC));
    rx_flit(f_rsvd(WA));
    rx_flit(f_body(WB));
    rx_flit(f_tail(WA));
    drain();
    check_val("err_rsvd", 64'(err_cnt_o), 64'd4);

    // RX with random consumer back-pressure
    rx_rand = 1'b1;
    rx_flit(f_head(NODE_ID, 4'd6, 8'd5));
    for (int i = 0; i < 6; i++) begin
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      rx_expect(4'd6, (i == 0), 1'b0, d);
      rx_flit(f_body(d));
    end
    rx_expect(4'd6, 1'b0, 1'b1, WB);
    rx_flit(f_tail(WB));
    drain();
    rx_rand = 1'b0;
    @(negedge clk);
    rx_rdy_i = 1'b1;
    @(posedge clk); #1;
    check_val("err_bp", 64'(err_cnt_o), 64'd4);

    // error counter saturation
    for (int i = 0; i < 250; i++) rx_flit(f_body(DATA_W'(i)));
    @(negedge clk);
    check_val("err_254", 64'(err_cnt_o), 64'd254);
    for (int i = 0; i < 50; i++) rx_flit(f_tail(DATA_W'(i)));
    @(negedge clk);
    check_val("err_sat", 64'(err_cnt_o), 64'd255);
    @(posedge clk); #1;

    // reset mid-packet on both sides
    mon_en    = 1'b0;
    out_rdy_i = 1'b1;
    cfg_dest_i = 4'd5;
    smp_data_i = WA;
    smp_vld_i  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    out_rdy_i = 1'b0;
    @(posedge clk); #1;
    smp_vld_i = 1'b0;
    rx_rdy_i  = 1'b0;
    in_flit_i = f_head(NODE_ID, 4'd4, 8'd9);
    in_vld_i  = 1'b1;
    @(posedge clk); #1;
    in_flit_i = f_body(WB);
    @(posedge clk); #1;
    in_vld_i = 1'b0;
    @(negedge clk);
    check_val("pre_rst_out_vld", 64'(out_vld_o), 64'd1);
    check_val("pre_rst_rx_vld", 64'(rx_vld_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("mid_rst_out_vld", 64'(out_vld_o), 64'd0);
    check_val("mid_rst_out_flit", 64'(out_flit_o), 64'd0);
    check_val("mid_rst_smp_rdy", 64'(smp_rdy_o), 64'd0);
    check_val("mid_rst_rx_vld", 64'(rx_vld_o), 64'd0);
    check_val("mid_rst_rx_src", 64'(rx_src_o), 64'd0);
    check_val("mid_rst_sop_eop", 64'({rx_sop_o, rx_eop_o}), 64'd0);
    check_val("mid_rst_err", 64'(err_cnt_o), 64'd0);
    @(posedge clk); #1;
    tx_q.delete();
    rx_q.delete();
    tb_seq    = '0;
    out_rdy_i = 1'b1;
    rx_rdy_i  = 1'b1;
    rst       = 1'b1;
    mon_en    = 1'b1;
    @(posedge clk); #1;

    // framing after reset restarts from seq 0
    tx_packet(4'd3, 1'b1);
    rx_expect(4'd8, 1'b1, 1'b0, WC);
    rx_expect(4'd8, 1'b0, 1'b1, WA);
    rx_flit(f_head(NODE_ID, 4'd8, 8'd0));
    rx_flit(f_body(WC));
    rx_flit(f_tail(WA));
    drain();
    check_val("err_post_rst", 64'(err_cnt_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
